// File: rtl/ivl_uvm_arb_pkg.sv
// Shared types and helpers for the ivl_uvm round-robin arbiter.
//   arb_state_e : arbiter FSM state (IDLE / BUSY)
//   rr_next     : round-robin pointer increment with wrap at n-1
package ivl_uvm_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Next pointer after a grant to 'ptr'; wraps n-1 back to 0.
    function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/ivl_uvm_rr_pick.sv
// Combinational round-robin picker.
// Finds the first set bit of req scanning ptr, ptr+1, ..., N-1, 0, ... .
//   req    : request vector
//   ptr    : scan start position
//   onehot : one-hot winner (all-zero when no request)
//   idx    : binary index of the winner (0 when no request)
//   any    : at least one request present
module ivl_uvm_rr_pick
    import ivl_uvm_arb_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         onehot,
    output logic [$clog2(N)-1:0] idx,
    output logic                 any
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned W2 = 2 * N;

    logic [W2-1:0] dbl;
    logic [W2-1:0] lo_mask;
    logic [W2-1:0] masked;

    // Duplicating req and masking off bits below ptr turns the wrapped scan
    // into a plain lowest-set-bit search; the upper copy supplies the wrap.
    always_comb begin
        dbl     = {req, req};
        lo_mask = (W2'(1) << ptr) - W2'(1);
        masked  = dbl & ~lo_mask;
        any     = |req;
        idx     = '0;
        for (int i = int'(W2) - 1; i >= 0; i--) begin
            if (masked[i]) begin
                idx = (i >= int'(N)) ? IW'(i - int'(N)) : IW'(i);
            end
        end
        onehot = any ? (N'(1) << idx) : '0;
    end

endmodule

// File: rtl/ivl_uvm_rr_arb.sv
// Round-robin arbiter feeding the OVL checker stage.
// Grants one of N requesters for one transfer; at most one grant bit is ever
// set and wr_val/wr_done are complementary decodes of one state flop.
//   clk         : clock, rising edge
//   reset       : asynchronous, active-high
//   req         : request vector
//   xfer_last   : final beat of the granted transfer (used in BUSY only)
//   arb_gnt_vec : registered one-hot grant, zero when idle
//   gnt_idx     : index of current / last grant
//   wr_val      : grant active
//   wr_done     : idle (always ~wr_val)
//   timeout     : one-cycle pulse on a hold-limit release
module ivl_uvm_rr_arb
    import ivl_uvm_arb_pkg::*;
#(
    parameter int unsigned N        = 8,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 xfer_last,
    output logic [N-1:0]         arb_gnt_vec,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 wr_val,
    output logic                 wr_done,
    output logic                 timeout
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(MAX_HOLD);

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   gnt_d;
    logic [IW-1:0]  idx_d;
    logic           timeout_d;

    logic [N-1:0]   pick_onehot;
    logic [IW-1:0]  pick_idx;
    logic           pick_any;

    ivl_uvm_rr_pick #(.N(N)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // State, pointer, hold counter and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            arb_gnt_vec <= '0;
            gnt_idx     <= '0;
            timeout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            arb_gnt_vec <= gnt_d;
            gnt_idx     <= idx_d;
            timeout     <= timeout_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        gnt_d     = arb_gnt_vec;
        idx_d     = gnt_idx;
        timeout_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_BUSY;
                    gnt_d   = pick_onehot;
                    idx_d   = pick_idx;
                    ptr_d   = IW'(rr_next(32'(pick_idx), N));
                    cnt_d   = '0;
                end
            end
            ARB_BUSY: begin
                // xfer_last and withdrawal outrank the hold limit, so a
                // coincident hold-limit hit does not pulse timeout.
                if (xfer_last || !req[gnt_idx]) begin
                    state_d = ARB_IDLE;
                    gnt_d   = '0;
                end else if (cnt_q == CW'(MAX_HOLD - 1)) begin
                    state_d   = ARB_IDLE;
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign wr_val  = (state_q == ARB_BUSY);
    assign wr_done = (state_q == ARB_IDLE);

endmodule

// File: doc/ivl_uvm_rr_arb.md
# ivl_uvm_rr_arb

Round-robin arbiter that drives the grant vector and write handshake pair (`arb_gnt_vec`, `wr_val`, `wr_done`) consumed by the OVL checker stage. It arbitrates `N` requesters, holds a one-hot grant for one transfer, and guarantees by construction the invariants the checkers assert: at most one grant bit set, and `wr_val != wr_done` in every cycle.

## Interface
- `N`, 8, number of requesters, range 2..32
- `MAX_HOLD`, 16, maximum cycles one grant may be held before forced release, ≥ 2
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `req`  in  N  request vector; bit i asserted while requester i wants the bus
- `xfer_last`  in  1  granted requester's final beat; sampled only in BUSY
- `arb_gnt_vec`  out  N  registered one-hot grant, all-zero when idle
- `gnt_idx`  out  $clog2(N)  binary index of the current/last grant
- `wr_val`  out  1  high while a grant is active (BUSY)
- `wr_done`  out  1  high while idle; always `~wr_val`
- `timeout`  out  1  one-cycle pulse when a grant is released by the hold limit

## Operation
- Reset values:
  - `arb_gnt_vec = 0`, `gnt_idx = 0`, `wr_val = 0`, `wr_done = 1`, `timeout = 0`.
  - State IDLE, round-robin pointer `ptr = 0`, hold counter 0.
- IDLE, `req == 0`: stay in IDLE, outputs unchanged.
- IDLE, `req != 0`: select the first set bit scanning `ptr, ptr+1, …, N-1, 0, …` (wrap modulo N).
  - Load the one-hot grant and `gnt_idx`.
  - Set `ptr = winner+1` (wraps at N-1 to 0).
  - Clear the hold counter, go to BUSY.
- BUSY: the hold counter increments every cycle, saturating at `MAX_HOLD-1`. Release (go to IDLE, grant cleared) on the first cycle any of these holds:
  - `xfer_last == 1`: normal release, `timeout = 0`.
  - `req[gnt_idx] == 0`: requester withdrew, normal release.
  - Counter equals `MAX_HOLD-1` without either of the above: forced release, `timeout = 1` for exactly one cycle.
- Simultaneous release causes: `xfer_last` takes priority; `timeout` is not pulsed.
- Requests from non-granted requesters during BUSY are ignored. No preemption.
- `gnt_idx` retains its last value in IDLE. `arb_gnt_vec` is zero in IDLE.
- `wr_val`/`wr_done` are decoded from a single registered state bit, so they are never equal and never glitch relative to each other.
- Reset asserted mid-BUSY: all outputs return to reset values asynchronously and `ptr` returns to 0.

## Timing
- Grant latency: `req` seen at edge t in IDLE produces `arb_gnt_vec`, `wr_val = 1` and `wr_done = 0` after edge t.
- Release latency: a release cause sampled at edge t clears the grant after edge t.
- At least one IDLE cycle always separates consecutive grants, so `wr_done` pulses high for ≥ 1 cycle between transfers.
- Maximum grant length is `MAX_HOLD` cycles; the forced release happens on the `MAX_HOLD`-th BUSY edge.
- Worst-case wait for a continuously requesting agent is `(N-1)*(MAX_HOLD+1)` cycles.

## Structure
- Package `ivl_uvm_arb_pkg` contains:
  - `typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e`
  - Function `rr_next(ptr, n)` for pointer wrap.
- Sub-module `ivl_uvm_rr_pick`:
  - Combinational, parameter `N`.
  - Inputs `req`, `ptr`; outputs `onehot`, `idx`, `any`.
  - Implemented as a double-width masked priority encode.
- Top level holds the FSM, pointer, hold counter and output registers. The combined size of the picker and the top level is within 120–400 lines.

## Test plan
- Reset check: `reset = 1` for 5 clocks with `req = 8'hFF` -> `arb_gnt_vec = 0`, `wr_val = 0`, `wr_done = 1` throughout; the bench's `ovl_always` checks stay silent.
- Single requester: `req = 8'h10`, `xfer_last` pulsed on the 3rd BUSY cycle:
  - `arb_gnt_vec = 8'h10`, `gnt_idx = 4` one cycle after the request.
  - Grant released the cycle after `xfer_last`; next `ptr = 5`.
- Fairness: `req = 8'hFF` held, each transfer ends with `xfer_last` after 2 cycles -> grants follow `01, 02, 04, …, 80, 01`, separated by single IDLE cycles; `$countones(arb_gnt_vec) <= 1` holds every cycle.
- Timeout: `req = 8'h01`, `xfer_last` never asserted, `MAX_HOLD = 16`:
  - Grant held exactly 16 cycles, then `timeout` pulses once and the block returns to IDLE.
  - Regrant to bit 0 follows one cycle later.
- Withdraw and priority: `req` goes `8'h04` -> `8'h00` during BUSY -> grant released next cycle, `timeout = 0`. A further test asserts `xfer_last` on the timeout cycle -> no `timeout` pulse.
- Reset mid-transfer: `reset` asserted asynchronously mid-BUSY -> outputs return to reset values immediately. After release with `req = 8'h80`, the grant goes to `8'h80` (scan restarts from `ptr = 0`).
